io_uart_fifo_port: RTL and testbench



---
 rtl/io_uart_pkg.sv | 24 ++
 rtl/io_uart_fifo_port_fifo.sv | 43 ++++
 rtl/io_uart_fifo_port.sv | 219 +++++++++++++++++++++
 tb/tb_io_uart_fifo_port.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// Shared constants, state encodings and helpers for the IO-port UART.
package io_uart_pkg;

    localparam logic [1:0] OFS_DATA = 2'd0;
    localparam logic [1:0] OFS_RXST = 2'd1;
    localparam logic [1:0] OFS_TXST = 2'd2;
    localparam logic [1:0] OFS_ERR  = 2'd3;

    localparam logic [7:0] ST_TRUE  = 8'hFF;
    localparam logic [7:0] ST_FALSE = 8'h00;

    localparam int unsigned ERR_FRAMING = 0;
    localparam int unsigned ERR_OVERRUN = 1;
    localparam int unsigned ERR_TXOVF   = 2;
    localparam int unsigned ERR_RXUNF   = 3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    function automatic logic [7:0] status_byte(input logic flag);
        return flag ? ST_TRUE : ST_FALSE;
    endfunction

endpackage

// File: rtl/io_uart_fifo_port_fifo.sv
// Synchronous byte FIFO; pointers carry a wrap bit to tell full from empty.
module io_sync_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // A push while full is refused even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/io_uart_fifo_port.sv
// IO-port mapped UART: data/status/error registers, TX and RX FIFOs, 8N1 serialiser.
module io_uart_fifo_port
    import io_uart_pkg::*;
#(
    parameter logic [7:0]  BASE_PORT    = 8'h01,
    parameter int unsigned TX_DEPTH     = 8,
    parameter int unsigned RX_DEPTH     = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk100,
    input  logic       reset_n,
    input  logic [7:0] IO_port_ID,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    output logic       uart_txd,
    input  logic       uart_rxd,
    output logic       irq
);
    localparam int unsigned  CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic       wr_q, rd_q;
    logic       wr_qual, rd_qual;
    logic [7:0] ofs_full;
    logic [1:0] ofs;
    logic       in_range;

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;

    logic [3:0] err_q, err_d, err_set;
    logic       err_clr;

    tx_state_e     tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          txd_q;
    logic          tx_bit_end;

    rx_state_e     rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_push_q, rx_frm_q;
    logic          rxd_s1_q, rxd_s2_q, rxd_prev_q;

    assign wr_qual  = IO_write_strobe && !wr_q;
    assign rd_qual  = IO_read_strobe && !rd_q;
    assign ofs_full = IO_port_ID - BASE_PORT;
    assign in_range = (ofs_full < 8'd4);
    assign ofs      = ofs_full[1:0];

    assign tx_push  = wr_qual && in_range && (ofs == OFS_DATA);
    assign rx_pop   = rd_qual && in_range && (ofs == OFS_DATA) && !rx_empty;

    io_sync_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk100),
        .rst_n (reset_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (IO_write_data),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    io_sync_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk100),
        .rst_n (reset_n),
        .push  (rx_push_q),
        .pop   (rx_pop),
        .din   (rx_shift_q),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Set terms are OR'd in after the clear so a coincident event survives the read.
    always_comb begin
        err_set              = '0;
        err_set[ERR_FRAMING] = rx_frm_q;
        err_set[ERR_OVERRUN] = rx_push_q && rx_full;
        err_set[ERR_TXOVF]   = tx_push && tx_full;
        err_set[ERR_RXUNF]   = rd_qual && in_range && (ofs == OFS_DATA) && rx_empty;
        err_clr              = rd_qual && in_range && (ofs == OFS_ERR);
        err_d                = (err_clr ? 4'b0000 : err_q) | err_set;
    end

    always_comb begin
        IO_read_data = 8'h00;
        if (IO_read_strobe && in_range) begin
            case (ofs)
                OFS_DATA: IO_read_data = rx_empty ? 8'h00 : rx_dout;
                OFS_RXST: IO_read_data = status_byte(!rx_empty);
                OFS_TXST: IO_read_data = status_byte(tx_full);
                default:  IO_read_data = {4'b0000, err_q};
            endcase
        end
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            err_q <= '0;
        end else begin
            wr_q  <= IO_write_strobe;
            rd_q  <= IO_read_strobe;
            err_q <= err_d;
        end
    end

    assign tx_bit_end = (tx_cnt_q == BIT_LAST);
    assign tx_pop     = !tx_empty &&
                        ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_bit_end));

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_cnt_q <= ((tx_state_q == TX_IDLE) || tx_bit_end) ? '0 : tx_cnt_q + 1'b1;
            case (tx_state_q)
                TX_IDLE: if (tx_pop) begin
                    tx_state_q <= TX_START;
                    tx_shift_q <= tx_dout;
                    txd_q      <= 1'b0;
                end
                TX_START: if (tx_bit_end) begin
                    tx_state_q <= TX_DATA;
                    tx_bit_q   <= '0;
                    txd_q      <= tx_shift_q[0];
                end
                TX_DATA: if (tx_bit_end) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= TX_STOP;
                        txd_q      <= 1'b1;
                    end else begin
                        tx_bit_q   <= tx_bit_q + 1'b1;
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        txd_q      <= tx_shift_q[1];
                    end
                end
                default: if (tx_bit_end) begin
                    // Next byte starts straight out of the stop bit, no idle gap.
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        tx_shift_q <= tx_dout;
                        txd_q      <= 1'b0;
                    end else begin
                        tx_state_q <= TX_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_push_q  <= 1'b0;
            rx_frm_q   <= 1'b0;
        end else begin
            rxd_s1_q   <= uart_rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
            rx_push_q  <= 1'b0;
            rx_frm_q   <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rxd_prev_q && !rxd_s2_q) rx_state_q <= RX_START;
                end
                RX_START: if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                default: if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= RX_IDLE;
                    if (rxd_s2_q) rx_push_q <= 1'b1;
                    else          rx_frm_q  <= 1'b1;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
            endcase
        end
    end

    assign uart_txd = txd_q;
    assign irq      = !rx_empty || (|err_q);

endmodule

// File: tb/tb_io_uart_fifo_port.sv
// Scoreboard bench for io_uart_fifo_port: read and serial-TX monitors pop expected queues.
module tb_io_uart_fifo_port;

    logic       clk100 = 1'b0;
    logic       reset_n;
    logic [7:0] IO_port_ID;
    logic [7:0] IO_write_data;
    logic       IO_write_strobe;
    logic       IO_read_strobe;
    logic [7:0] IO_read_data;
    logic       uart_txd;
    logic       uart_rxd;
    logic       irq;

    int checks = 0;
    int errors = 0;
    int abort_req = 0;
    logic [7:0] exp_rd[$];
    logic [7:0] exp_tx[$];

    always #5 clk100 = ~clk100;

    io_uart_fifo_port #(
        .BASE_PORT    (8'h01),
        .TX_DEPTH     (4),
        .RX_DEPTH     (4),
        .CLKS_PER_BIT (4)
    ) dut (
        .clk100          (clk100),
        .reset_n         (reset_n),
        .IO_port_ID      (IO_port_ID),
        .IO_write_data   (IO_write_data),
        .IO_write_strobe (IO_write_strobe),
        .IO_read_strobe  (IO_read_strobe),
        .IO_read_data    (IO_read_data),
        .uart_txd        (uart_txd),
        .uart_rxd        (uart_rxd),
        .irq             (irq)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read monitor: a rising read strobe is the DUT presenting read data.
    initial begin : rd_mon
        logic prev;
        logic [7:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk100);
            if (IO_read_strobe && !prev) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %h with no expected read queued", IO_read_data);
                end else begin
                    e = exp_rd.pop_front();
                    check($sformatf("rd_port_%h", IO_port_ID), IO_read_data, e);
                end
            end
            prev = IO_read_strobe;
        end
    end

    // Serial monitor: decodes 8N1 frames from uart_txd at mid-bit.
    initial begin : tx_mon
        logic prev, st, sp;
        logic [7:0] b, e;
        int abort_seen;
        prev = 1'b1;
        abort_seen = 0;
        forever begin
            @(negedge clk100);
            if (prev && !uart_txd) begin
                repeat (2) @(negedge clk100);
                st = uart_txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk100);
                    b[i] = uart_txd;
                end
                repeat (4) @(negedge clk100);
                sp = uart_txd;
                prev = uart_txd;
                if (abort_seen != abort_req) begin
                    abort_seen = abort_req;
                end else if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got frame %h with none expected", b);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_byte", b, e);
                    check("tx_start_stop", {6'b0, st, sp}, 8'h01);
                end
            end else begin
                prev = uart_txd;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        @(posedge clk100); #1;
        IO_port_ID      = port;
        IO_write_data   = data;
        IO_write_strobe = 1'b1;
        @(posedge clk100); #1;
        IO_write_strobe = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] port, input logic [7:0] exp, input int hold);
        @(posedge clk100); #1;
        IO_port_ID     = port;
        IO_read_strobe = 1'b1;
        exp_rd.push_back(exp);
        repeat (hold) @(posedge clk100);
        #1 IO_read_strobe = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        @(posedge clk100); #1 uart_rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(posedge clk100);
            #1 uart_rxd = d[i];
        end
        repeat (4) @(posedge clk100); #1 uart_rxd = stop;
        repeat (4) @(posedge clk100); #1 uart_rxd = 1'b1;
        repeat (8) @(posedge clk100);
    endtask

    task automatic wait_tx_drain(input int budget);
        int n;
        n = 0;
        while (exp_tx.size() != 0 && n < budget) begin
            @(negedge clk100);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL tx_drain_timeout: %0d frames outstanding, need 0", exp_tx.size());
        end
        repeat (6) @(negedge clk100);
    endtask

    initial begin : stim
        reset_n         = 1'b0;
        IO_port_ID      = 8'h00;
        IO_write_data   = 8'h00;
        IO_write_strobe = 1'b0;
        IO_read_strobe  = 1'b0;
        uart_rxd        = 1'b1;
        repeat (3) @(posedge clk100);
        #1 reset_n = 1'b1;

        @(negedge clk100);
        check("reset_txd", {7'b0, uart_txd}, 8'h01);
        check("reset_irq", {7'b0, irq}, 8'h00);
        check("reset_rdata", IO_read_data, 8'h00);
        io_read(8'h02, 8'h00, 1);
        io_read(8'h03, 8'h00, 1);
        io_read(8'h04, 8'h00, 1);

        // 8'hA5: start bit must appear two cycles after the strobe
        @(posedge clk100); #1;
        IO_port_ID = 8'h01; IO_write_data = 8'hA5; IO_write_strobe = 1'b1;
        exp_tx.push_back(8'hA5);
        @(negedge clk100);
        check("tx_lat_c0", {7'b0, uart_txd}, 8'h01);
        @(posedge clk100); #1 IO_write_strobe = 1'b0;
        @(negedge clk100);
        check("tx_lat_c1", {7'b0, uart_txd}, 8'h01);
        @(negedge clk100);
        check("tx_lat_c2", {7'b0, uart_txd}, 8'h00);
        wait_tx_drain(200);

        // TX overflow: 0F occupies the serialiser, 10..13 fill the FIFO, 14 is dropped
        io_write(8'h01, 8'h0F); exp_tx.push_back(8'h0F);
        for (int k = 0; k < 4; k++) begin
            io_write(8'h01, 8'h10 + 8'(k));
            exp_tx.push_back(8'h10 + 8'(k));
        end
        io_read(8'h03, 8'hFF, 1);
        io_write(8'h01, 8'h14);
        io_read(8'h04, 8'h04, 1);
        io_read(8'h04, 8'h00, 1);
        wait_tx_drain(600);

        // Out-of-range and non-data writes do nothing
        io_write(8'h05, 8'h99);
        io_write(8'h00, 8'h99);
        io_write(8'h02, 8'h55);
        repeat (6) @(negedge clk100);
        check("oor_txd_idle", {7'b0, uart_txd}, 8'h01);
        io_read(8'h05, 8'h00, 1);
        io_read(8'h00, 8'h00, 1);

        // RX good frame
        send_rx(8'h3C, 1'b1);
        io_read(8'h02, 8'hFF, 1);
        @(negedge clk100) check("irq_rx_present", {7'b0, irq}, 8'h01);
        io_read(8'h01, 8'h3C, 1);
        io_read(8'h02, 8'h00, 1);
        @(negedge clk100) check("irq_rx_empty", {7'b0, irq}, 8'h00);

        // Framing error
        send_rx(8'h55, 1'b0);
        io_read(8'h04, 8'h01, 1);
        io_read(8'h02, 8'h00, 1);

        // RX overrun: fifth byte dropped, first four kept
        for (int k = 1; k <= 5; k++) send_rx(8'(k), 1'b1);
        io_read(8'h04, 8'h02, 1);
        for (int k = 1; k <= 4; k++) io_read(8'h01, 8'(k), 1);
        io_read(8'h02, 8'h00, 1);

        // Underflow with held strobe
        io_read(8'h01, 8'h00, 3);
        io_read(8'h04, 8'h08, 1);
        io_read(8'h04, 8'h00, 1);
        @(negedge clk100) check("irq_cleared", {7'b0, irq}, 8'h00);

        // Reset mid-frame with TX FIFO full
        io_write(8'h01, 8'h77);
        for (int k = 0; k < 4; k++) io_write(8'h01, 8'h81 + 8'(k));
        io_read(8'h03, 8'hFF, 1);
        repeat (6) @(posedge clk100);
        abort_req++;
        #3 reset_n = 1'b0;
        #1 check("rst_txd_async", {7'b0, uart_txd}, 8'h01);
        exp_tx.delete();
        repeat (3) @(posedge clk100);
        #1 reset_n = 1'b1;
        io_read(8'h03, 8'h00, 1);
        io_read(8'h02, 8'h00, 1);
        repeat (60) @(negedge clk100);
        check("post_rst_txd_idle", {7'b0, uart_txd}, 8'h01);

        repeat (4) @(negedge clk100);
        check("tx_queue_drained", 8'(exp_tx.size()), 8'h00);
        check("rd_queue_drained", 8'(exp_rd.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
